sha256_stream_ctrl: RTL and testbench
=====================================

SHA256_STREAM_CTRL -- requirements
Module: sha256_stream_ctrl

Interface
REQ-001 Parameter CORE_LAT, default 65, cycles from stable core inputs to valid core_hash; legal range 1..255.
REQ-002 Parameter IV, default 256'h5be0cd191f83d9ab9b05688c510e527fa54ff53a3c6ef372bb67ae856a09e667, initial chaining state, word a at [31:0].
REQ-003 aclk  in  1  clock; all logic on rising edge.
REQ-004 aresetn  in  1  reset, synchronous, active-low.
REQ-005 rd_tvalid  in  1  input block valid.
REQ-006 rd_tready  out  1  input block accepted when high with rd_tvalid.
REQ-007 rd_tdata  in  512  one pre-padded 512-bit message block, core format.
REQ-008 rd_tlast  in  1  block is the final block of its message.
REQ-009 wr_tvalid  out  1  digest valid.
REQ-010 wr_tready  in  1  downstream accepts digest.
REQ-011 wr_tdata  out  512  [255:0] digest {h,g,f,e,d,c,b,a}, a at [31:0]; [511:256] zero.
REQ-012 wr_tlast  out  1  equals wr_tvalid.
REQ-013 core_state  out  256  chaining state to sha256_transform rx_state.
REQ-014 core_block  out  512  block to sha256_transform rx_input.
REQ-015 core_hash  in  256  sha256_transform tx_hash.
REQ-016 busy  out  1  high whenever FSM is not IDLE.
REQ-017 msg_count  out  32  completed digests handed off, wraps at 2^32.
REQ-018 blk_count  out  32  blocks accepted, wraps at 2^32.

Function
REQ-019 FSM states IDLE, RUN, OUT.
REQ-020 rd_tready SHALL be 1 only in IDLE; accepted block and rd_tlast are registered; FSM moves IDLE->RUN on that edge (E0); blk_count increments.
REQ-021 core_block and core_state SHALL be registered and held stable from E0 until the block's hash is sampled.
REQ-022 In RUN an 8-bit counter SHALL count from 0; core_hash sampled at edge E0+CORE_LAT, no earlier.
REQ-023 On sampling, chain SHALL update per 32-bit word: chain[i] <= chain[i] + core_hash[i] mod 2^32, no carry between words.
REQ-024 At sampling edge: stored tlast=0 -> IDLE, chain retained; tlast=1 -> OUT.
REQ-025 Throughput: one block per CORE_LAT+1 cycles; rd_tready reasserts the cycle after the sampling edge.
REQ-026 In OUT, wr_tvalid=wr_tlast=1, wr_tdata = updated chain, stable until wr_tready.
REQ-027 OUT with wr_tready=1: chain <= IV, msg_count increments, FSM -> IDLE same edge; wr_tvalid low next cycle.
REQ-028 OUT with wr_tready=0: hold indefinitely, rd_tready stays 0 (back-pressure).
REQ-029 rd_tvalid in RUN/OUT is ignored; data not captured; no loss as rd_tready=0.
REQ-030 Single-block message (tlast on first block) SHALL produce digest of IV+hash.
REQ-031 Counter wraps at 2^32 with no flag or stall.

Reset
REQ-032 Reset SHALL force IDLE, chain=IV, core_state=IV, core_block=0, counter=0, msg_count=0, blk_count=0, wr_tvalid=wr_tlast=0, wr_tdata=0, busy=0; rd_tready=1 from first cycle after reset release.
REQ-033 Reset in RUN or OUT SHALL abandon the message with no digest output; next accepted block starts from IV.

Verification
REQ-034 "abc" padded single block, tlast=1, wr_tready=1 -> wr_tvalid exactly CORE_LAT+1 cycles after accept; a=ba7816bf, h=f20015ad; msg_count=1.
REQ-035 Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> one digest, a=248d6a61, h=19db06c1; blk_count=2; no output after block 1.
REQ-036 wr_tready low 10 cycles in OUT -> wr_tdata stable, rd_tready=0 throughout, rd_tvalid blocks not consumed; handoff on first tready cycle.
REQ-037 Back-to-back "abc" messages -> identical digests; second starts from IV; msg_count=2.
REQ-038 Reset asserted mid-RUN of block 1 of 2 -> no wr_tvalid; subsequent "abc" yields a=ba7816bf.
REQ-039 rd_tvalid held high during RUN -> exactly one block captured per CORE_LAT+1 cycles; blk_count matches handshakes.

Source files
------------

// File: rtl/sha256_stream_ctrl.sv
// Streaming controller around an external sha256_transform core: accepts one
// pre-padded block at a time, chains the per-block hashes, emits the digest.
module sha256_stream_ctrl #(
    parameter int unsigned  CORE_LAT = 65,
    parameter logic [255:0] IV       = 256'h5be0cd191f83d9ab9b05688c510e527fa54ff53a3c6ef372bb67ae856a09e667
) (
    input  logic         aclk,
    input  logic         aresetn,

    input  logic         rd_tvalid,
    output logic         rd_tready,
    input  logic [511:0] rd_tdata,
    input  logic         rd_tlast,

    output logic         wr_tvalid,
    input  logic         wr_tready,
    output logic [511:0] wr_tdata,
    output logic         wr_tlast,

    output logic [255:0] core_state,
    output logic [511:0] core_block,
    input  logic [255:0] core_hash,

    output logic         busy,
    output logic [31:0]  msg_count,
    output logic [31:0]  blk_count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OUT
    } state_t;

    // Counter value seen just before the edge that lands CORE_LAT edges after acceptance.
    localparam logic [7:0] LAST_CNT = 8'(CORE_LAT - 1);

    state_t       state_q, state_d;
    logic [255:0] chain_q, chain_d;
    logic [255:0] core_state_q, core_state_d;
    logic [511:0] core_block_q, core_block_d;
    logic         last_q, last_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [31:0]  msg_count_q, msg_count_d;
    logic [31:0]  blk_count_q, blk_count_d;
    logic         wr_tvalid_q, wr_tvalid_d;
    logic [255:0] digest_q, digest_d;
    logic         rd_tready_q, rd_tready_d;
    logic         busy_q, busy_d;
    logic [255:0] chain_sum;

    // Word-wise feed-forward; each 32-bit lane wraps independently.
    always_comb begin
        chain_sum = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            chain_sum[32*i +: 32] = chain_q[32*i +: 32] + core_hash[32*i +: 32];
        end
    end

    always_comb begin
        state_d      = state_q;
        chain_d      = chain_q;
        core_state_d = core_state_q;
        core_block_d = core_block_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        msg_count_d  = msg_count_q;
        blk_count_d  = blk_count_q;
        wr_tvalid_d  = wr_tvalid_q;
        digest_d     = digest_q;
        rd_tready_d  = rd_tready_q;
        busy_d       = busy_q;

        case (state_q)
            IDLE: begin
                if (rd_tvalid && rd_tready_q) begin
                    core_block_d = rd_tdata;
                    core_state_d = chain_q;
                    last_d       = rd_tlast;
                    cnt_d        = '0;
                    blk_count_d  = blk_count_q + 32'd1;
                    state_d      = RUN;
                    rd_tready_d  = 1'b0;
                    busy_d       = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q == LAST_CNT) begin
                    chain_d = chain_sum;
                    if (last_q) begin
                        state_d     = OUT;
                        wr_tvalid_d = 1'b1;
                        digest_d    = chain_sum;
                    end else begin
                        state_d     = IDLE;
                        rd_tready_d = 1'b1;
                        busy_d      = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            OUT: begin
                if (wr_tready) begin
                    chain_d     = IV;
                    msg_count_d = msg_count_q + 32'd1;
                    state_d     = IDLE;
                    wr_tvalid_d = 1'b0;
                    rd_tready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                wr_tvalid_d = 1'b0;
                rd_tready_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            chain_q      <= IV;
            core_state_q <= IV;
            core_block_q <= '0;
            last_q       <= 1'b0;
            cnt_q        <= '0;
            msg_count_q  <= '0;
            blk_count_q  <= '0;
            wr_tvalid_q  <= 1'b0;
            digest_q     <= '0;
            rd_tready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            chain_q      <= chain_d;
            core_state_q <= core_state_d;
            core_block_q <= core_block_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            msg_count_q  <= msg_count_d;
            blk_count_q  <= blk_count_d;
            wr_tvalid_q  <= wr_tvalid_d;
            digest_q     <= digest_d;
            rd_tready_q  <= rd_tready_d;
            busy_q       <= busy_d;
        end
    end

    assign rd_tready  = rd_tready_q;
    assign wr_tvalid  = wr_tvalid_q;
    assign wr_tlast   = wr_tvalid_q;
    assign wr_tdata   = {{256{1'b0}}, digest_q};
    assign core_state = core_state_q;
    assign core_block = core_block_q;
    assign busy       = busy_q;
    assign msg_count  = msg_count_q;
    assign blk_count  = blk_count_q;

endmodule

// File: tb/tb_sha256_stream_ctrl.sv
// Directed bench for sha256_stream_ctrl with a behavioural sha256_transform stand-in
// whose output is garbage until CORE_LAT cycles after a block is accepted.
module tb_sha256_stream_ctrl;

    localparam int unsigned  CORE_LAT = 65;
    localparam logic [255:0] IV = 256'h5be0cd191f83d9ab9b05688c510e527fa54ff53a3c6ef372bb67ae856a09e667;
    localparam logic [255:0] ABC_D = 256'hf20015ad_b410ff61_96177a9c_b00361a3_5dae2223_414140de_8f01cfea_ba7816bf;
    localparam logic [255:0] TWO_D = 256'h19db06c1_f6ecedd4_64ff2167_a33ce459_0c3e6039_e5c02693_d20638b8_248d6a61;
    localparam logic [2047:0] K_ALL = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         rd_tvalid, rd_tready, rd_tlast;
    logic [511:0] rd_tdata;
    logic         wr_tvalid, wr_tready, wr_tlast;
    logic [511:0] wr_tdata;
    logic [255:0] core_state, core_hash;
    logic [511:0] core_block;
    logic         busy;
    logic [31:0]  msg_count, blk_count;

    int n_vec = 0;
    int n_err = 0;
    int exp_blk = 0;
    int exp_msg = 0;
    int lat_cnt = 1000;
    logic [511:0] abc_blk, two_blk1, two_blk2;

    sha256_stream_ctrl #(.CORE_LAT(CORE_LAT), .IV(IV)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .rd_tvalid(rd_tvalid), .rd_tready(rd_tready), .rd_tdata(rd_tdata), .rd_tlast(rd_tlast),
        .wr_tvalid(wr_tvalid), .wr_tready(wr_tready), .wr_tdata(wr_tdata), .wr_tlast(wr_tlast),
        .core_state(core_state), .core_block(core_block), .core_hash(core_hash),
        .busy(busy), .msg_count(msg_count), .blk_count(blk_count)
    );

    always #5 aclk = ~aclk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Raw compression result (working variables, no feed-forward); a at [31:0], W0 at blk[31:0].
    function automatic logic [255:0] sha_compress(input logic [255:0] st, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        logic [2047:0] kk;
        kk = K_ALL;
        for (int t = 0; t < 16; t++) w[t] = blk[32*t +: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        a = st[31:0];    b = st[63:32];   c = st[95:64];   d = st[127:96];
        e = st[159:128]; f = st[191:160]; g = st[223:192]; h = st[255:224];
        for (int t = 0; t < 64; t++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + kk[32*(63-t) +: 32] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h, g, f, e, d, c, b, a};
    endfunction

    always @(posedge aclk) begin
        if (rd_tvalid && rd_tready) lat_cnt <= 0;
        else if (lat_cnt < 1000) lat_cnt <= lat_cnt + 1;
    end

    always_comb begin
        core_hash = {8{32'hdeadbeef}};
        if (lat_cnt >= int'(CORE_LAT) - 1) core_hash = sha_compress(core_state, core_block);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_block(input logic [511:0] blk, input logic last, output bit to);
        int k = 0;
        to = 1'b0;
        rd_tdata = blk; rd_tlast = last; rd_tvalid = 1'b1;
        while (!rd_tready && k < 2000) begin @(negedge aclk); k++; end
        if (!rd_tready) to = 1'b1;
        else begin @(negedge aclk); exp_blk++; end
        rd_tvalid = 1'b0;
    endtask

    task automatic wait_out(input int max, output int n);
        n = 0;
        while (!wr_tvalid && n < max) begin @(negedge aclk); n++; end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (wr_tvalid !== 1'b0 || wr_tlast !== 1'b0) begin n_err++; $display("FAIL reset_wr: got valid %b last %b want 0 0", wr_tvalid, wr_tlast); end
        n_vec++; if (wr_tdata !== '0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", wr_tdata); end
        n_vec++; if (msg_count !== 0 || blk_count !== 0) begin n_err++; $display("FAIL reset_counts: got msg %0d blk %0d want 0 0", msg_count, blk_count); end
        n_vec++; if (core_state !== IV) begin n_err++; $display("FAIL reset_core_state: got %h want %h", core_state, IV); end
        n_vec++; if (core_block !== '0) begin n_err++; $display("FAIL reset_core_block: got %h want 0", core_block); end
        aresetn = 1'b1;
        @(negedge aclk);
        n_vec++; if (rd_tready !== 1'b1) begin n_err++; $display("FAIL reset_rd_tready: got %b want 1", rd_tready); end
        exp_blk = 0; exp_msg = 0;
    endtask

    task automatic test_single_abc();
        bit to; int n;
        wr_tready = 1'b1;
        send_block(abc_blk, 1'b1, to);
        n_vec++; if (to) begin n_err++; $display("FAIL single_accept: got timeout want handshake"); end
        n_vec++; if (core_state !== IV) begin n_err++; $display("FAIL single_core_state: got %h want %h", core_state, IV); end
        wait_out(1000, n);
        n_vec++; if (n != int'(CORE_LAT)) begin n_err++; $display("FAIL single_latency: got %0d edges want %0d", n, CORE_LAT); end
        n_vec++; if (wr_tdata !== {256'd0, ABC_D}) begin n_err++; $display("FAIL single_digest: got %h want %h", wr_tdata[255:0], ABC_D); end
        n_vec++; if (wr_tdata[31:0] !== 32'hba7816bf || wr_tdata[255:224] !== 32'hf20015ad) begin n_err++; $display("FAIL single_a_h: got a %h h %h want ba7816bf f20015ad", wr_tdata[31:0], wr_tdata[255:224]); end
        n_vec++; if (wr_tlast !== 1'b1 || busy !== 1'b1 || rd_tready !== 1'b0) begin n_err++; $display("FAIL single_out_flags: got last %b busy %b rdy %b want 1 1 0", wr_tlast, busy, rd_tready); end
        @(negedge aclk);
        exp_msg++;
        n_vec++; if (wr_tvalid !== 1'b0 || rd_tready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL single_handoff: got valid %b rdy %b busy %b want 0 1 0", wr_tvalid, rd_tready, busy); end
        n_vec++; if (msg_count !== 32'(exp_msg) || blk_count !== 32'(exp_blk)) begin n_err++; $display("FAIL single_counts: got msg %0d blk %0d want %0d %0d", msg_count, blk_count, exp_msg, exp_blk); end
    endtask

    task automatic test_two_block();
        bit to; int n; int early = 0;
        wr_tready = 1'b1;
        send_block(two_blk1, 1'b0, to);
        n = 0;
        while (!rd_tready && n < 1000) begin
            if (wr_tvalid) early++;
            @(negedge aclk); n++;
        end
        n_vec++; if (n != int'(CORE_LAT)) begin n_err++; $display("FAIL two_ready_return: got %0d edges want %0d", n, CORE_LAT); end
        n_vec++; if (early != 0 || wr_tvalid !== 1'b0) begin n_err++; $display("FAIL two_no_output_blk1: got %0d valid cycles want 0", early); end
        send_block(two_blk2, 1'b1, to);
        wait_out(1000, n);
        n_vec++; if (to || n != int'(CORE_LAT)) begin n_err++; $display("FAIL two_latency: got %0d edges timeout %b want %0d", n, to, CORE_LAT); end
        n_vec++; if (wr_tdata !== {256'd0, TWO_D}) begin n_err++; $display("FAIL two_digest: got %h want %h", wr_tdata[255:0], TWO_D); end
        n_vec++; if (wr_tdata[31:0] !== 32'h248d6a61 || wr_tdata[255:224] !== 32'h19db06c1) begin n_err++; $display("FAIL two_a_h: got a %h h %h want 248d6a61 19db06c1", wr_tdata[31:0], wr_tdata[255:224]); end
        @(negedge aclk);
        exp_msg++;
        n_vec++; if (blk_count !== 32'(exp_blk) || msg_count !== 32'(exp_msg)) begin n_err++; $display("FAIL two_counts: got blk %0d msg %0d want %0d %0d", blk_count, msg_count, exp_blk, exp_msg); end
    endtask

    task automatic test_backpressure();
        bit to; int n; int bad = 0;
        wr_tready = 1'b0;
        send_block(abc_blk, 1'b1, to);
        wait_out(1000, n);
        n_vec++; if (to || wr_tvalid !== 1'b1) begin n_err++; $display("FAIL bp_out: got valid %b timeout %b want 1 0", wr_tvalid, to); end
        rd_tdata = two_blk1; rd_tlast = 1'b1; rd_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            if (wr_tvalid !== 1'b1 || wr_tdata !== {256'd0, ABC_D} || rd_tready !== 1'b0 || blk_count !== 32'(exp_blk)) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad); end
        rd_tvalid = 1'b0; wr_tready = 1'b1;
        @(negedge aclk);
        exp_msg++;
        n_vec++; if (wr_tvalid !== 1'b0 || msg_count !== 32'(exp_msg) || blk_count !== 32'(exp_blk)) begin n_err++; $display("FAIL bp_handoff: got valid %b msg %0d blk %0d want 0 %0d %0d", wr_tvalid, msg_count, blk_count, exp_msg, exp_blk); end
    endtask

    task automatic test_back_to_back();
        bit to; int n;
        logic [255:0] d [2];
        wr_tready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            send_block(abc_blk, 1'b1, to);
            wait_out(1000, n);
            d[k] = wr_tdata[255:0];
            @(negedge aclk);
            exp_msg++;
        end
        n_vec++; if (d[0] !== ABC_D) begin n_err++; $display("FAIL b2b_first: got %h want %h", d[0], ABC_D); end
        n_vec++; if (d[1] !== ABC_D) begin n_err++; $display("FAIL b2b_second: got %h want %h", d[1], ABC_D); end
        n_vec++; if (msg_count !== 32'(exp_msg)) begin n_err++; $display("FAIL b2b_msg_count: got %0d want %0d", msg_count, exp_msg); end
    endtask

    task automatic test_stream_throughput();
        int hs = 0; int last_i = 0; int gap_bad = 0; int outs = 0;
        int span = 3 * (int'(CORE_LAT) + 1);
        wr_tready = 1'b1;
        rd_tdata = abc_blk; rd_tlast = 1'b0; rd_tvalid = 1'b1;
        for (int i = 0; i <= span; i++) begin
            if (wr_tvalid) outs++;
            if (rd_tready) begin
                if (hs > 0 && (i - last_i) != int'(CORE_LAT) + 1) gap_bad++;
                last_i = i; hs++;
            end
            @(negedge aclk);
        end
        rd_tvalid = 1'b0;
        exp_blk += 4;
        n_vec++; if (hs != 4 || gap_bad != 0) begin n_err++; $display("FAIL stream_rate: got %0d handshakes %0d bad gaps want 4 0", hs, gap_bad); end
        n_vec++; if (blk_count !== 32'(exp_blk)) begin n_err++; $display("FAIL stream_blk_count: got %0d want %0d", blk_count, exp_blk); end
        n_vec++; if (outs != 0) begin n_err++; $display("FAIL stream_no_output: got %0d valid cycles want 0", outs); end
    endtask

    task automatic test_reset_mid_run();
        bit to; int n; int outs = 0;
        aresetn = 1'b0; repeat (2) @(negedge aclk); aresetn = 1'b1;
        exp_blk = 0; exp_msg = 0;
        wr_tready = 1'b1;
        send_block(two_blk1, 1'b0, to);
        repeat (20) @(negedge aclk);
        aresetn = 1'b0; repeat (2) @(negedge aclk); aresetn = 1'b1;
        exp_blk = 0;
        n_vec++; if (busy !== 1'b0 || core_state !== IV || rd_tready !== 1'b1 || blk_count !== 0) begin n_err++; $display("FAIL midrst_state: got busy %b rdy %b blk %0d state %h want 0 1 0 IV", busy, rd_tready, blk_count, core_state); end
        for (int i = 0; i < int'(CORE_LAT) + 10; i++) begin
            if (wr_tvalid) outs++;
            @(negedge aclk);
        end
        n_vec++; if (outs != 0) begin n_err++; $display("FAIL midrst_no_output: got %0d valid cycles want 0", outs); end
        send_block(abc_blk, 1'b1, to);
        wait_out(1000, n);
        n_vec++; if (to || n != int'(CORE_LAT) || wr_tdata !== {256'd0, ABC_D}) begin n_err++; $display("FAIL midrst_abc: got %h after %0d edges want %h after %0d", wr_tdata[255:0], n, ABC_D, CORE_LAT); end
        @(negedge aclk);
        exp_msg++;
        n_vec++; if (msg_count !== 32'(exp_msg) || blk_count !== 32'(exp_blk)) begin n_err++; $display("FAIL midrst_counts: got msg %0d blk %0d want %0d %0d", msg_count, blk_count, exp_msg, exp_blk); end
    endtask

    initial begin
        logic [31:0] m [14];
        m = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a,
              32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071};
        abc_blk = '0; abc_blk[31:0] = 32'h61626380; abc_blk[511:480] = 32'h00000018;
        two_blk1 = '0;
        for (int i = 0; i < 14; i++) two_blk1[32*i +: 32] = m[i];
        two_blk1[479:448] = 32'h80000000;
        two_blk2 = '0; two_blk2[511:480] = 32'h000001c0;

        aresetn = 1'b0; rd_tvalid = 1'b0; rd_tdata = '0; rd_tlast = 1'b0; wr_tready = 1'b0;
        @(negedge aclk);
        test_reset();
        test_single_abc();
        test_two_block();
        test_backpressure();
        test_back_to_back();
        test_stream_throughput();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
